sdram_ctrl: RTL and testbench



---
 rtl/sdram_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sdram_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ctrl.sv
// Single-access SDRAM controller: power-up init, periodic auto-refresh and
// byte-wide read/write with auto-precharge on a 16-bit SDRAM.
module sdram_ctrl #(
  parameter int INIT_CYCLES    = 5600,
  parameter int REFRESH_CYCLES = 420,
  parameter int TRCD           = 2,
  parameter int TRP            = 2,
  parameter int TRFC           = 4,
  parameter int CL             = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [24:0] a,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        ready,
  output logic        busy,
  output logic        dramCe,
  output logic        dramCs,
  output logic        dramRas,
  output logic        dramCas,
  output logic        dramWe,
  output logic [1:0]  dramDQM,
  inout  wire  [15:0] dramDQ,
  output logic [1:0]  dramBA,
  output logic [12:0] dramA,
  output logic [3:0]  o_dbg_state
);

  // Handshake: rd/wr are sampled only on a clock where busy is low; the
  // requester holds its request until then, and ready pulses once on completion.

  localparam int TW = $clog2(INIT_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);

  localparam logic [TW-1:0] L_INIT_LAST = TW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] L_TRP_LAST  = TW'(TRP - 1);
  localparam logic [TW-1:0] L_TRFC_LAST = TW'(TRFC - 1);
  localparam logic [TW-1:0] L_TRCD_LAST = TW'(TRCD - 1);
  localparam logic [TW-1:0] L_MRS_LAST  = TW'(1);
  localparam logic [TW-1:0] L_WR_LAST   = TW'(TRP + 1);
  localparam logic [TW-1:0] L_RD_DATA   = TW'(CL);
  localparam logic [TW-1:0] L_RD_LAST   = TW'(CL + 1);
  localparam logic [RW-1:0] L_REF_LAST  = RW'(REFRESH_CYCLES - 1);
  localparam logic [12:0]   MODE_REG    = 13'(CL << 4);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_REF, S_ACT, S_TRCD, S_WRITE, S_READ
  } state_t;

  state_t        r_state, w_state;
  logic [TW-1:0] r_timer, w_timer;
  logic [3:0]    r_cmd, w_cmd;
  logic [12:0]   r_dram_a, w_dram_a;
  logic [1:0]    r_dram_ba, w_dram_ba;
  logic [1:0]    r_dqm, w_dqm;
  logic          r_dq_oe, w_dq_oe;
  logic [15:0]   r_dq_out, w_dq_out;
  logic [7:0]    r_q, w_q;
  logic          r_ready, w_ready;
  logic          r_busy, w_busy;
  logic [24:0]   r_addr, w_addr;
  logic [7:0]    r_data, w_data;
  logic          r_op_wr, w_op_wr;
  logic          r_init_done, w_init_done;
  logic          r_cke;
  logic          w_ref_issue;
  logic [RW-1:0] r_ref_cnt;
  logic          r_ref_pend;

  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer + TW'(1);
    w_cmd       = CMD_NOP;
    w_dram_a    = r_dram_a;
    w_dram_ba   = r_dram_ba;
    w_dqm       = r_dqm;
    w_dq_oe     = 1'b0;
    w_dq_out    = r_dq_out;
    w_q         = r_q;
    w_ready     = 1'b0;
    w_busy      = r_busy;
    w_addr      = r_addr;
    w_data      = r_data;
    w_op_wr     = r_op_wr;
    w_init_done = r_init_done;
    w_ref_issue = 1'b0;
    case (r_state)
      S_INIT_WAIT: if (r_timer == L_INIT_LAST) begin
        w_cmd     = CMD_PRE;
        w_dram_a  = 13'h0400;
        w_dram_ba = 2'b00;
        w_state   = S_INIT_PRE;
        w_timer   = '0;
      end
      S_INIT_PRE: if (r_timer == L_TRP_LAST) begin
        w_cmd   = CMD_REF;
        w_state = S_INIT_REF1;
        w_timer = '0;
      end
      S_INIT_REF1: if (r_timer == L_TRFC_LAST) begin
        w_cmd   = CMD_REF;
        w_state = S_INIT_REF2;
        w_timer = '0;
      end
      S_INIT_REF2: if (r_timer == L_TRFC_LAST) begin
        w_cmd     = CMD_MRS;
        w_dram_a  = MODE_REG;
        w_dram_ba = 2'b00;
        w_state   = S_INIT_MRS;
        w_timer   = '0;
      end
      S_INIT_MRS: if (r_timer == L_MRS_LAST) begin
        w_state     = S_IDLE;
        w_busy      = 1'b0;
        w_init_done = 1'b1;
        w_timer     = '0;
      end
      S_IDLE: begin
        w_timer = '0;
        // A pending refresh always wins over a waiting request.
        if (r_ref_pend) begin
          w_cmd       = CMD_REF;
          w_busy      = 1'b1;
          w_ref_issue = 1'b1;
          w_state     = S_REF;
        end else if (rd || wr) begin
          w_addr  = a;
          w_data  = d;
          w_op_wr = wr;
          w_busy  = 1'b1;
          w_state = S_ACT;
        end
      end
      S_REF: if (r_timer == L_TRFC_LAST) begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
        w_timer = '0;
      end
      S_ACT: begin
        w_cmd     = CMD_ACT;
        w_dram_ba = r_addr[24:23];
        w_dram_a  = r_addr[22:10];
        w_state   = S_TRCD;
        w_timer   = '0;
      end
      S_TRCD: if (r_timer == L_TRCD_LAST) begin
        w_dram_a = {3'b001, 1'b0, r_addr[9:1]};
        w_timer  = '0;
        if (r_op_wr) begin
          w_cmd    = CMD_WRITE;
          w_dq_oe  = 1'b1;
          w_dq_out = {r_data, r_data};
          w_dqm    = r_addr[0] ? 2'b01 : 2'b10;
          w_state  = S_WRITE;
        end else begin
          w_cmd   = CMD_READ;
          w_dqm   = 2'b00;
          w_state = S_READ;
        end
      end
      S_WRITE: begin
        if (r_timer == '0) begin
          w_dqm   = 2'b11;
          w_ready = 1'b1;
        end
        if (r_timer == L_WR_LAST) begin
          w_busy  = 1'b0;
          w_state = S_IDLE;
          w_timer = '0;
        end
      end
      S_READ: begin
        // Data for the READ issued at T3 is on the bus at the CL+1-th edge after it.
        if (r_timer == L_RD_DATA) begin
          w_q     = r_addr[0] ? dramDQ[15:8] : dramDQ[7:0];
          w_ready = 1'b1;
        end
        if (r_timer == L_RD_LAST) begin
          w_dqm   = 2'b11;
          w_busy  = 1'b0;
          w_state = S_IDLE;
          w_timer = '0;
        end
      end
      default: begin
        w_state = S_INIT_WAIT;
        w_timer = '0;
        w_busy  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_INIT_WAIT;
      r_timer     <= '0;
      r_cmd       <= CMD_NOP;
      r_dram_a    <= '0;
      r_dram_ba   <= '0;
      r_dqm       <= 2'b11;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
      r_q         <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
      r_addr      <= '0;
      r_data      <= '0;
      r_op_wr     <= 1'b0;
      r_init_done <= 1'b0;
      r_cke       <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_timer     <= w_timer;
      r_cmd       <= w_cmd;
      r_dram_a    <= w_dram_a;
      r_dram_ba   <= w_dram_ba;
      r_dqm       <= w_dqm;
      r_dq_oe     <= w_dq_oe;
      r_dq_out    <= w_dq_out;
      r_q         <= w_q;
      r_ready     <= w_ready;
      r_busy      <= w_busy;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_op_wr     <= w_op_wr;
      r_init_done <= w_init_done;
      r_cke       <= 1'b1;
    end
  end

  // Free-running refresh timer; a wrap on the same clock as a service keeps the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else if (r_init_done) begin
      if (r_ref_cnt == L_REF_LAST) begin
        r_ref_cnt  <= '0;
        r_ref_pend <= 1'b1;
      end else begin
        r_ref_cnt <= r_ref_cnt + RW'(1);
        if (w_ref_issue) r_ref_pend <= 1'b0;
      end
    end
  end

  assign dramCe      = r_cke;
  assign dramCs      = r_cmd[3];
  assign dramRas     = r_cmd[2];
  assign dramCas     = r_cmd[1];
  assign dramWe      = r_cmd[0];
  assign dramDQM     = r_dqm;
  assign dramBA      = r_dram_ba;
  assign dramA       = r_dram_a;
  assign dramDQ      = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign q           = r_q;
  assign ready       = r_ready;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Bench for sdram_ctrl: SDRAM device model, byte-addressed reference memory,
// cycle-timeline checks relative to request acceptance, and refresh monitoring.
module tb_sdram_ctrl;

  localparam int INIT_CYCLES    = 5600;
  localparam int REFRESH_CYCLES = 420;
  localparam int TRCD           = 2;
  localparam int TRP            = 2;
  localparam int TRFC           = 4;
  localparam int CL             = 2;
  localparam int REF_LIMIT      = REFRESH_CYCLES + TRFC + 7;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [24:0] a;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        ready, busy;
  logic        dramCe, dramCs, dramRas, dramCas, dramWe;
  logic [1:0]  dramDQM, dramBA;
  logic [12:0] dramA;
  logic [3:0]  dbg_state;
  wire  [15:0] dramDQ;

  sdram_ctrl #(
    .INIT_CYCLES(INIT_CYCLES), .REFRESH_CYCLES(REFRESH_CYCLES),
    .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .CL(CL)
  ) dut (
    .clock(clock), .reset(reset), .rd(rd), .wr(wr), .a(a), .d(d),
    .q(q), .ready(ready), .busy(busy),
    .dramCe(dramCe), .dramCs(dramCs), .dramRas(dramRas), .dramCas(dramCas),
    .dramWe(dramWe), .dramDQM(dramDQM), .dramDQ(dramDQ), .dramBA(dramBA),
    .dramA(dramA), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [logic [24:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] cur_cmd();
    return {dramCs, dramRas, dramCas, dramWe};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [24:0] addr);
    return ref_mem.exists(addr) ? ref_mem[addr] : 8'h00;
  endfunction

  // ---------------- SDRAM device model ----------------
  logic [15:0] sd_mem [logic [23:0]];
  logic [12:0] sd_row [4];
  logic        sd_oe = 1'b0;
  logic [15:0] sd_dq = '0;
  logic        rd_s1 = 1'b0;
  logic [15:0] rd_w1 = '0;
  assign dramDQ = sd_oe ? sd_dq : 16'hzzzz;

  always @(posedge clock) begin
    logic [3:0]  mc;
    logic [23:0] key;
    logic [15:0] w;
    logic        drv;
    logic [15:0] drv_w;
    mc    = cur_cmd();
    drv   = rd_s1;
    drv_w = rd_w1;
    rd_s1 = 1'b0;
    key   = {dramBA, sd_row[dramBA], dramA[8:0]};
    if (mc == CMD_ACT) sd_row[dramBA] = dramA;
    if (mc == CMD_WRITE) begin
      w = sd_mem.exists(key) ? sd_mem[key] : 16'h0000;
      if (!dramDQM[0]) w[7:0]  = dramDQ[7:0];
      if (!dramDQM[1]) w[15:8] = dramDQ[15:8];
      sd_mem[key] = w;
    end
    if (mc == CMD_READ) begin
      rd_s1 = 1'b1;
      rd_w1 = sd_mem.exists(key) ? sd_mem[key] : 16'h0000;
    end
    #1;
    sd_oe = drv;
    sd_dq = drv_w;
  end

  // ---------------- refresh monitor ----------------
  logic mon_en = 1'b0;
  int   last_ref = -1;
  int   n_ref = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (cur_cmd() == CMD_REF) begin
        if (last_ref >= 0) check("ref_gap_le_limit", 32'((cyc - last_ref) <= REF_LIMIT), 32'd1);
        last_ref = cyc;
        n_ref++;
      end
      if (cur_cmd() == CMD_ACT && last_ref >= 0)
        check("act_after_ref_ge_trfc", 32'((cyc - last_ref) >= TRFC), 32'd1);
    end
  end

  // ---------------- driver / checking tasks ----------------
  task automatic check_reset_vals();
    check("rst_cmd", 32'(cur_cmd()), 32'(CMD_NOP));
    check("rst_cke", 32'(dramCe), 32'd1);
    check("rst_dqm", 32'(dramDQM), 32'd3);
    check("rst_a", 32'(dramA), 32'd0);
    check("rst_ba", 32'(dramBA), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_cmd(output int g);
    g = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      g++;
      if (cur_cmd() != CMD_NOP) break;
    end
  endtask

  // Called with reset just released, before the first active edge.
  task automatic check_init();
    int n;
    int g;
    n = 0;
    for (int i = 0; i < INIT_CYCLES + 50; i++) begin
      @(negedge clock);
      if (cur_cmd() != CMD_NOP) break;
      n++;
    end
    check("init_nop_count", 32'(n), 32'(INIT_CYCLES));
    check("init_pre_cmd", 32'(cur_cmd()), 32'(CMD_PRE));
    check("init_pre_a10", 32'(dramA[10]), 32'd1);
    wait_cmd(g);
    check("init_ref1_cmd", 32'(cur_cmd()), 32'(CMD_REF));
    check("init_ref1_gap", 32'(g), 32'(TRP));
    wait_cmd(g);
    check("init_ref2_cmd", 32'(cur_cmd()), 32'(CMD_REF));
    check("init_ref2_gap", 32'(g), 32'(TRFC));
    wait_cmd(g);
    check("init_mrs_cmd", 32'(cur_cmd()), 32'(CMD_MRS));
    check("init_mrs_gap", 32'(g), 32'(TRFC));
    check("init_mrs_a", 32'(dramA), 32'h020);
    g = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      g++;
      if (!busy) break;
    end
    check("init_busy_fall", 32'(g), 32'd2);
  endtask

  // Returns at the sample right after the acceptance edge (T0).
  task automatic wait_accept(output bit found);
    logic pb;
    pb    = busy;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (busy && !pb && cur_cmd() != CMD_REF) begin
        found = 1'b1;
        break;
      end
      pb = busy;
    end
  endtask

  task automatic do_access(input logic t_rd, input logic t_wr, input logic [24:0] t_a,
                           input logic [7:0] t_d);
    bit          found;
    bit          is_wr;
    int          ready_k;
    logic [12:0] exp_col;
    @(negedge clock);
    rd = t_rd; wr = t_wr; a = t_a; d = t_d;
    is_wr   = t_wr;
    ready_k = is_wr ? 4 : CL + 4;
    exp_col = 13'h0400 | {4'b0000, t_a[9:1]};
    if (is_wr) ref_mem[t_a] = t_d;
    else exp_q.push_back(ref_byte(t_a));
    wait_accept(found);
    check("accept", 32'(found), 32'd1);
    if (!found) begin
      rd = 1'b0; wr = 1'b0;
      if (!is_wr) void'(exp_q.pop_back());
      return;
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check("act_cmd", 32'(cur_cmd()), 32'(CMD_ACT));
        check("act_ba", 32'(dramBA), 32'(t_a[24:23]));
        check("act_row", 32'(dramA), 32'(t_a[22:10]));
      end
      if (k == 2) check("t2_nop", 32'(cur_cmd()), 32'(CMD_NOP));
      if (k == 1 + TRCD) begin
        check("rw_cmd", 32'(cur_cmd()), 32'(is_wr ? CMD_WRITE : CMD_READ));
        check("rw_ba", 32'(dramBA), 32'(t_a[24:23]));
        check("rw_col_a10", 32'(dramA), 32'(exp_col));
        check("rw_dqm", 32'(dramDQM), 32'(is_wr ? (t_a[0] ? 2'b01 : 2'b10) : 2'b00));
        if (is_wr) check("wr_dq", 32'(dramDQ), 32'({t_d, t_d}));
      end
      if (k == 4 && is_wr) check("wr_dqm_release", 32'(dramDQM), 32'd3);
      check("ready_timing", 32'(ready), 32'(k == ready_k));
      if (k == ready_k) begin
        if (!is_wr) check("rd_data", 32'(q), 32'(exp_q.pop_front()));
        rd = 1'b0; wr = 1'b0;
      end
      check("busy_timing", 32'(busy), 32'(k != 7));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          found;
    int          ready_cnt;
    logic [24:0] ra;
    logic [7:0]  held_exp;
    int          r;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; a = '0; d = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals();
    @(posedge clock); #1 reset = 1'b0;
    check_init();
    last_ref = -1;
    mon_en   = 1'b1;

    // Directed write/read of the documented example address.
    do_access(1'b0, 1'b1, 25'h1234567, 8'hA5);
    do_access(1'b1, 1'b0, 25'h1234567, 8'h00);
    // rd and wr together must write; the other lane of the word stays untouched.
    do_access(1'b1, 1'b1, 25'h0000ABC, 8'h3C);
    do_access(1'b1, 1'b0, 25'h0000ABC, 8'h00);
    do_access(1'b1, 1'b0, 25'h0000ABD, 8'h00);

    // Randomized traffic over a small address pool to get read-after-write hits.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) ra = 25'($urandom);
      else ra = {2'($urandom_range(0, 3)), 13'($urandom_range(0, 3)),
                 9'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      r = $urandom_range(0, 9);
      if (r < 4)      do_access(1'b1, 1'b0, ra, 8'h00);
      else if (r < 8) do_access(1'b0, 1'b1, ra, 8'($urandom));
      else            do_access(1'b1, 1'b1, ra, 8'($urandom));
      repeat ($urandom_range(0, 4)) @(negedge clock);
    end

    // Read held continuously: refresh must still be serviced on time.
    n_ref     = 0;
    ready_cnt = 0;
    held_exp  = ref_byte(25'h1234567);
    @(negedge clock);
    rd = 1'b1; wr = 1'b0; a = 25'h1234567;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (ready) begin
        ready_cnt++;
        check("held_rd_data", 32'(q), 32'(held_exp));
      end
    end
    rd = 1'b0;
    check("held_ref_count", 32'(n_ref >= 4), 32'd1);
    check("held_read_count", 32'(ready_cnt >= 150), 32'd1);

    // Reset asserted at T4 of a read.
    mon_en = 1'b0;
    @(negedge clock);
    rd = 1'b1; a = 25'h1234567;
    wait_accept(found);
    check("rst_test_accept", 32'(found), 32'd1);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    rd    = 1'b0;
    #1;
    check_reset_vals();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("rst_no_ready", 32'(ready), 32'd0);
      check("rst_busy_hold", 32'(busy), 32'd1);
    end
    @(posedge clock); #1 reset = 1'b0;
    check_init();
    last_ref = -1;
    mon_en   = 1'b1;
    do_access(1'b0, 1'b1, 25'h1FFFFFE, 8'h5A);
    do_access(1'b1, 1'b0, 25'h1FFFFFE, 8'h00);
    do_access(1'b1, 1'b0, 25'h1234567, 8'h00);

    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
